// File: rtl/ioram_pkg.sv
// Shared defaults and enums for the I/O RAM arbiter: FSM states and requester ids.
package ioram_pkg;
    localparam int DEPTH_DEF  = 10240;
    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 8;

    typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;
    typedef enum logic {PORT_CPU = 1'b0, PORT_VID = 1'b1} port_id_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: same-cycle grants, pointer remembers the last winner.
module rr_arbiter2
    import ioram_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_cpu,
    input  logic req_vid,
    output logic gnt_cpu,
    output logic gnt_vid
);
    port_id_t last;

    always_comb begin
        gnt_cpu = 1'b0;
        gnt_vid = 1'b0;
        if (en) begin
            if (req_cpu && req_vid) begin
                gnt_cpu = (last == PORT_VID);
                gnt_vid = (last == PORT_CPU);
            end else begin
                gnt_cpu = req_cpu;
                gnt_vid = req_vid;
            end
        end
    end

    // Reset to "video won last" so the CPU is favoured first.
    always_ff @(posedge clk) begin
        if (rst)          last <= PORT_VID;
        else if (gnt_cpu) last <= PORT_CPU;
        else if (gnt_vid) last <= PORT_VID;
    end
endmodule

// File: rtl/ioram_arbiter.sv
// Single-port I/O RAM arbiter between CPU and video scanner, with a zero-fill sweep engine.
module ioram_arbiter
    import ioram_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CpuReq,
    input  logic              CpuWe,
    input  logic [ADDR_W-1:0] CpuAddr,
    input  logic [DATA_W-1:0] CpuWData,
    output logic              CpuGnt,
    output logic              CpuRdValid,
    output logic [DATA_W-1:0] CpuRData,
    input  logic              VidReq,
    input  logic [ADDR_W-1:0] VidAddr,
    output logic              VidGnt,
    output logic              VidRdValid,
    output logic [DATA_W-1:0] VidRData,
    input  logic              ClrStart,
    input  logic [ADDR_W-1:0] ClrBase,
    input  logic [ADDR_W-1:0] ClrLen,
    output logic              ClrBusy,
    output logic              ClrDone,
    output logic              AddrErr,
    output logic [ADDR_W-1:0] RamAddr,
    output logic [DATA_W-1:0] RamDataWrite,
    output logic              RamWrEnable,
    input  logic [DATA_W-1:0] RamDataRead
);
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_addr, clr_rem;
    logic              gnt_cpu, gnt_vid;
    logic              rv_cpu, rv_vid, rv_oor, addr_err_q;

    // Outputs are forced quiet while rst is held, even before the reset edge lands.
    wire               live     = !rst;
    wire               arb_en   = live && (state == ST_IDLE);
    wire               any_gnt  = gnt_cpu || gnt_vid;
    wire [ADDR_W-1:0]  acc_addr = gnt_cpu ? CpuAddr : VidAddr;
    wire               acc_ok   = {1'b0, acc_addr} < DEPTH_X;
    wire               acc_we   = gnt_cpu && CpuWe;
    wire               clr_ok   = (clr_rem != '0) && ({1'b0, clr_addr} < DEPTH_X);

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .en      (arb_en),
        .req_cpu (CpuReq),
        .req_vid (VidReq),
        .gnt_cpu (gnt_cpu),
        .gnt_vid (gnt_vid)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (ClrStart) state_nxt = ST_CLEAR;
            ST_CLEAR: if (!clr_ok)  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_addr <= '0;
            clr_rem  <= '0;
        end else if (state == ST_IDLE && ClrStart) begin
            clr_addr <= ClrBase;
            clr_rem  <= ClrLen;
        end else if (state == ST_CLEAR && clr_ok) begin
            clr_addr <= clr_addr + 1'b1;
            clr_rem  <= clr_rem - 1'b1;
        end
    end

    // Return tag: which port owns next cycle's RamDataRead, and whether it was out of range.
    always_ff @(posedge clk) begin
        if (rst) begin
            rv_cpu     <= 1'b0;
            rv_vid     <= 1'b0;
            rv_oor     <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            rv_cpu     <= gnt_cpu && !CpuWe;
            rv_vid     <= gnt_vid;
            rv_oor     <= !acc_ok;
            addr_err_q <= any_gnt && !acc_ok;
        end
    end

    always_comb begin
        RamAddr      = '0;
        RamDataWrite = '0;
        RamWrEnable  = 1'b0;
        ClrBusy      = 1'b0;
        ClrDone      = 1'b0;
        if (live) begin
            case (state)
                ST_IDLE: if (any_gnt && acc_ok) begin
                    RamAddr      = acc_addr;
                    RamWrEnable  = acc_we;
                    RamDataWrite = acc_we ? CpuWData : '0;
                end
                ST_CLEAR: begin
                    ClrBusy = 1'b1;
                    if (clr_ok) begin
                        RamAddr     = clr_addr;
                        RamWrEnable = 1'b1;
                    end else begin
                        ClrDone = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign CpuGnt     = gnt_cpu;
    assign VidGnt     = gnt_vid;
    assign CpuRdValid = live && rv_cpu;
    assign VidRdValid = live && rv_vid;
    assign CpuRData   = (CpuRdValid && !rv_oor) ? RamDataRead : '0;
    assign VidRData   = (VidRdValid && !rv_oor) ? RamDataRead : '0;
    assign AddrErr    = live && addr_err_q;
endmodule

// File: doc/ioram_arbiter.md
IORAM_ARBITER -- requirements
Module: ioram_arbiter

Interface
REQ-001 Parameter DEPTH, default 10240: number of valid I/O RAM locations (0..DEPTH-1).
REQ-002 Parameter ADDR_W, default 14: address width.
REQ-003 Parameter DATA_W, default 8: data width.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  system clock, all state on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 CpuReq / CpuWe / CpuAddr / CpuWData  in  1/1/ADDR_W/DATA_W  CPU request, write flag, address, write data.
REQ-008 CpuGnt / CpuRdValid / CpuRData  out  1/1/DATA_W  CPU grant, read-return strobe, read data.
REQ-009 VidReq / VidAddr  in  1/ADDR_W  read-only video scanner request and address.
REQ-010 VidGnt / VidRdValid / VidRData  out  1/1/DATA_W  video grant, return strobe, data.
REQ-011 ClrStart / ClrBase / ClrLen  in  1/ADDR_W/ADDR_W  clear-sweep start pulse, first address, byte count.
REQ-012 ClrBusy / ClrDone  out  1/1  sweep in progress, 1-cycle completion pulse.
REQ-013 AddrErr  out  1  1-cycle pulse on a granted out-of-range access.
REQ-014 RamAddr / RamDataWrite / RamWrEnable  out  ADDR_W/DATA_W/1  drive to the synchronous I/O RAM.
REQ-015 RamDataRead  in  DATA_W  RAM read data, valid the cycle after the address was presented with RamWrEnable=0.

Function
REQ-016 FSM states IDLE (arbitrate) and CLEAR (sweep); at most one RAM access per cycle.
REQ-017 IDLE: Gnt is combinational and same-cycle; a requester holds Req and its payload until Gnt is seen high.
REQ-018 Single requester in IDLE: granted that cycle.
REQ-019 Both requesters in IDLE: round-robin, granting the port not granted most recently; the pointer updates only on a grant; after reset CPU wins first.
REQ-020 Granted access: RamAddr/RamDataWrite/RamWrEnable driven from the winner the same cycle; video always drives RamWrEnable=0.
REQ-021 Granted read at cycle N: the owner's RdValid=1 in cycle N+1 with RData=RamDataRead; back-to-back reads from either port in consecutive cycles are allowed.
REQ-022 CPU write: no RdValid is generated.
REQ-023 Address >= DEPTH: access is still granted; RamWrEnable=0; RamAddr=0; AddrErr pulses in cycle N+1; a read returns RdValid in N+1 with RData=0x00.
REQ-024 RData=0x00 whenever RdValid=0; no idle-cycle RAM enables (RamWrEnable=0, RamAddr=0).
REQ-025 ClrStart is honoured only in IDLE and ignored otherwise; requests in the start cycle are still arbitrated; CLEAR is entered next cycle.
REQ-026 CLEAR: writes 0x00 at ClrBase+i, one per cycle, i=0..ClrLen-1; base/len latched at start; writes at addresses >= DEPTH are suppressed and end the sweep early.
REQ-027 CLEAR: ClrBusy=1; all Gnt=0; pending requests wait; the return of a read granted in the start cycle is still delivered.
REQ-028 ClrDone pulses in the cycle after the last write; FSM returns to IDLE that cycle; ClrLen=0 gives ClrDone the cycle after start with no writes.

Reset
REQ-029 On rst: FSM=IDLE; round-robin pointer favours CPU; all outputs 0; the in-flight read tag is cleared, so no RdValid follows reset.
REQ-030 rst during CLEAR aborts the sweep without ClrDone; already-written bytes remain.

Structure
REQ-031 Package ioram_pkg holds DEPTH/ADDR_W/DATA_W defaults, the FSM state enum, and the port-id enum (PORT_CPU, PORT_VID).
REQ-032 One sub-module, rr_arbiter2 (2-way round-robin with pointer); the clear counter and return tag stay in the top module.

Verification
REQ-033 CPU write 0x2A@0x0010, then CPU read 0x0010 -> CpuGnt same cycle; CpuRdValid next cycle, CpuRData=0x2A.
REQ-034 CpuReq and VidReq held for 4 cycles -> grants alternate CPU,VID,CPU,VID; each RdValid on the correct port one cycle later.
REQ-035 CPU read 0x2800 (10240) -> RamWrEnable=0, AddrErr pulse and CpuRdValid with CpuRData=0x00 next cycle.
REQ-036 ClrStart, base 0x27FE, len 5 -> writes only 0x27FE and 0x27FF; ClrDone after 2 writes; VidReq held throughout is granted only after ClrDone.
REQ-037 ClrLen=0 -> ClrDone next cycle, no RamWrEnable; rst asserted mid-sweep at base 0, len 100 -> no ClrDone, outputs 0, IDLE.
